// File: rtl/prga.sv
// prga: RC4 keystream generator that decrypts a length-prefixed ciphertext memory into plaintext.
// Optional printable-ASCII verdict on pt_ok is enabled with `define PRGA_ASCII_CHECK_EN.
module prga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output logic       pt_ok
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        GET_LEN,
        WR_LEN,
        RD_SI,
        GET_SI,
        RD_SJ,
        GET_SJ,
        WR_SI,
        WR_SJ,
        PAD_IDX,
        RD_PAD,
        GET_PAD,
        WR_PT,
        DONE
    } state_t;

    state_t     state, state_nx;
    logic [7:0] i, j, k, len;
    logic [7:0] si, sj, pidx, pad, c;
    logic [7:0] pt_byte;

    assign pt_byte = pad ^ c;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Write enables are gated by rst_n so a reset landing on a write state issues nothing.
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        s_addr    = 8'h00;
        s_wrdata  = 8'h00;
        s_wren    = 1'b0;
        ct_addr   = 8'h00;
        pt_addr   = 8'h00;
        pt_wrdata = 8'h00;
        pt_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_nx = RD_LEN;
            end
            RD_LEN: begin
                ct_addr  = 8'h00;
                state_nx = GET_LEN;
            end
            GET_LEN: state_nx = WR_LEN;
            WR_LEN: begin
                pt_addr   = 8'h00;
                pt_wrdata = len;
                pt_wren   = rst_n;
                state_nx  = (len == 8'h00) ? DONE : RD_SI;
            end
            RD_SI: begin
                s_addr   = i + 8'd1;
                state_nx = GET_SI;
            end
            GET_SI: state_nx = RD_SJ;
            RD_SJ: begin
                s_addr   = j;
                state_nx = GET_SJ;
            end
            GET_SJ: state_nx = WR_SI;
            WR_SI: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = rst_n;
                state_nx = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = rst_n;
                state_nx = PAD_IDX;
            end
            // Registers si+sj so the pad read address comes straight from a flop.
            PAD_IDX: state_nx = RD_PAD;
            RD_PAD: begin
                s_addr   = pidx;
                ct_addr  = k;
                state_nx = GET_PAD;
            end
            GET_PAD: state_nx = WR_PT;
            WR_PT: begin
                pt_addr   = k;
                pt_wrdata = pt_byte;
                pt_wren   = rst_n;
                state_nx  = (k == len) ? DONE : RD_SI;
            end
            DONE: begin
                rdy      = 1'b1;
                state_nx = en ? RD_LEN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i    <= 8'h00;
            j    <= 8'h00;
            k    <= 8'h00;
            len  <= 8'h00;
            si   <= 8'h00;
            sj   <= 8'h00;
            pidx <= 8'h00;
            pad  <= 8'h00;
            c    <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    i <= 8'h00;
                    j <= 8'h00;
                    k <= 8'h00;
                end
                GET_LEN: len <= ct_rddata;
                WR_LEN:  k <= 8'd1;
                RD_SI:   i <= i + 8'd1;
                GET_SI: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                GET_SJ:  sj <= s_rddata;
                PAD_IDX: pidx <= si + sj;
                GET_PAD: begin
                    pad <= s_rddata;
                    c   <= ct_rddata;
                end
                WR_PT: if (k != len) k <= k + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef PRGA_ASCII_CHECK_EN
    logic ok_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            ok_q <= 1'b1;
        else if (rdy && en)
            ok_q <= 1'b0;
        else if (state == WR_LEN)
            ok_q <= 1'b1;
        else if (state == WR_PT && (pt_byte < 8'h20 || pt_byte > 8'h7E))
            ok_q <= 1'b0;
    end
    assign pt_ok = ok_q;
`else
    assign pt_ok = 1'b1;
`endif

endmodule
